// File: rtl/rs_issue_select_if.sv
// Issue-slot handshake between rs_issue_select and the functional unit.
// master: issue stage drives valid/instr/rd/idx, FU drives ready.
interface rs_issue_select_if #(
  parameter int TAG_WIDTH = 7,
  parameter int IDX_WIDTH = 2
);
  logic                 issue_valid;
  logic                 issue_ready;
  logic [31:0]          issue_instr;
  logic [TAG_WIDTH-1:0] issue_rd;
  logic [IDX_WIDTH-1:0] issue_idx;

  modport master (
    output issue_valid,
    output issue_instr,
    output issue_rd,
    output issue_idx,
    input  issue_ready
  );

  modport slave (
    input  issue_valid,
    input  issue_instr,
    input  issue_rd,
    input  issue_idx,
    output issue_ready
  );
endinterface

// File: rtl/rs_issue_select.sv
// Issue select: oldest operand-ready station entry into a registered slot.
// Ports: clock/reset, station entry state, alloc, flush, issue if, clear.
module rs_issue_select #(
  parameter int NUM_ENTRIES = 4,
  parameter int IDX_WIDTH   = 2,
  parameter int TAG_WIDTH   = 7,
  parameter int AGE_WIDTH   = 3
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_ENTRIES-1:0]         ent_valid,
  input  logic [NUM_ENTRIES-1:0]         ent_rs1_ready,
  input  logic [NUM_ENTRIES-1:0]         ent_rs2_ready,
  input  logic [NUM_ENTRIES*32-1:0]      ent_instr,
  input  logic [NUM_ENTRIES*TAG_WIDTH-1:0] ent_rd,
  input  logic                           alloc_en,
  input  logic [IDX_WIDTH-1:0]           alloc_idx,
  input  logic                           flush,
  rs_issue_select_if.master              iss,
  output logic                           clear,
  output logic [IDX_WIDTH-1:0]           clear_idx
);

  typedef enum logic {
    IDLE,
    HOLD
  } state_t;

  localparam logic [AGE_WIDTH-1:0] AGE_MAX = '1;

  state_t                 state_q, state_d;
  logic [AGE_WIDTH-1:0]   age_q [NUM_ENTRIES];
  logic [AGE_WIDTH-1:0]   age_d [NUM_ENTRIES];
  logic [31:0]            instr_q, instr_d;
  logic [TAG_WIDTH-1:0]   rd_q, rd_d;
  logic [IDX_WIDTH-1:0]   idx_q, idx_d;

  logic                   valid;
  logic [NUM_ENTRIES-1:0] cand;
  logic                   any;
  logic [IDX_WIDTH-1:0]   win_idx;
  logic [AGE_WIDTH-1:0]   win_age;
  logic [31:0]            win_instr;
  logic [TAG_WIDTH-1:0]   win_rd;
  logic                   kill;

  assign valid = (state_q == HOLD);

  assign iss.issue_valid = valid;
  assign iss.issue_instr = instr_q;
  assign iss.issue_rd    = rd_q;
  assign iss.issue_idx   = idx_q;
  assign clear_idx       = idx_q;

  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      age_d[i] = age_q[i];
      if (alloc_en && alloc_idx == IDX_WIDTH'(i)) begin
        age_d[i] = '0;
      end else if (ent_valid[i] && age_q[i] != AGE_MAX) begin
        age_d[i] = age_q[i] + 1'b1;
      end
    end
  end

  // The held entry stays valid in the station until cleared,
  // so it must be masked out to avoid issuing it twice.
  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      cand[i] = ent_valid[i] & ent_rs1_ready[i] & ent_rs2_ready[i]
              & ~(valid && idx_q == IDX_WIDTH'(i));
    end
  end

  // Strict '>' keeps the lower index on equal age.
  always_comb begin
    any       = 1'b0;
    win_idx   = '0;
    win_age   = '0;
    win_instr = '0;
    win_rd    = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (cand[i] && (!any || age_q[i] > win_age)) begin
        any       = 1'b1;
        win_idx   = IDX_WIDTH'(i);
        win_age   = age_q[i];
        win_instr = ent_instr[32*i +: 32];
        win_rd    = ent_rd[TAG_WIDTH*i +: TAG_WIDTH];
      end
    end
  end

  assign kill = flush | ~ent_valid[idx_q];

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    rd_d    = rd_q;
    idx_d   = idx_q;
    clear   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any && !flush) begin
          state_d = HOLD;
          instr_d = win_instr;
          rd_d    = win_rd;
          idx_d   = win_idx;
        end
      end
      HOLD: begin
        if (kill) begin
          state_d = IDLE;
        end else if (iss.issue_ready) begin
          clear = 1'b1;
          if (any) begin
            instr_d = win_instr;
            rd_d    = win_rd;
            idx_d   = win_idx;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (reset) begin
      clear = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      instr_q <= '0;
      rd_q    <= '0;
      idx_q   <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        age_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      rd_q    <= rd_d;
      idx_q   <= idx_d;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        age_q[i] <= age_d[i];
      end
    end
  end

endmodule

// File: tb/tb_rs_issue_select.sv
// Directed bench for rs_issue_select.
// Models the station: sets entries on alloc, drops them on clear.
module tb_rs_issue_select;

  logic         clock = 1'b0;
  logic         reset;
  logic [3:0]   ent_valid;
  logic [3:0]   ent_rs1_ready;
  logic [3:0]   ent_rs2_ready;
  logic [127:0] ent_instr;
  logic [27:0]  ent_rd;
  logic         alloc_en;
  logic [1:0]   alloc_idx;
  logic         flush;
  logic         clear;
  logic [1:0]   clear_idx;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  rs_issue_select_if #(.TAG_WIDTH(7), .IDX_WIDTH(2)) iss ();

  rs_issue_select #(
    .NUM_ENTRIES(4),
    .IDX_WIDTH  (2),
    .TAG_WIDTH  (7),
    .AGE_WIDTH  (3)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .ent_valid    (ent_valid),
    .ent_rs1_ready(ent_rs1_ready),
    .ent_rs2_ready(ent_rs2_ready),
    .ent_instr    (ent_instr),
    .ent_rd       (ent_rd),
    .alloc_en     (alloc_en),
    .alloc_idx    (alloc_idx),
    .flush        (flush),
    .iss          (iss.master),
    .clear        (clear),
    .clear_idx    (clear_idx)
  );

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock; the station drops an entry on the edge that clears it.
  task automatic cyc();
    logic       c;
    logic [1:0] ci;
    #1;
    c  = clear;
    ci = clear_idx;
    @(posedge clock);
    #1;
    if (c) ent_valid[ci] = 1'b0;
    #1;
  endtask

  task automatic alloc(int idx, logic [31:0] ins, logic [6:0] rd,
                       logic r1, logic r2);
    alloc_en  = 1'b1;
    alloc_idx = 2'(idx);
    cyc();
    alloc_en = 1'b0;
    ent_valid[idx]       = 1'b1;
    ent_rs1_ready[idx]   = r1;
    ent_rs2_ready[idx]   = r2;
    ent_instr[32*idx +: 32] = ins;
    ent_rd[7*idx +: 7]      = rd;
    #1;
  endtask

  task automatic pulse(int idx);
    alloc_en  = 1'b1;
    alloc_idx = 2'(idx);
    cyc();
    alloc_en = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    ent_valid     = '0;
    ent_rs1_ready = '0;
    ent_rs2_ready = '0;
    ent_instr     = '0;
    ent_rd        = '0;
    alloc_en      = 1'b0;
    alloc_idx     = '0;
    flush         = 1'b0;
    iss.issue_ready = 1'b0;
    repeat (2) cyc();
    check("rst_valid", 32'(iss.issue_valid), 0);
    check("rst_instr", iss.issue_instr, 0);
    check("rst_rd", 32'(iss.issue_rd), 0);
    check("rst_idx", 32'(iss.issue_idx), 0);
    check("rst_clear", 32'(clear), 0);
    reset = 1'b0;
    cyc();

    // basic issue of entry2
    iss.issue_ready = 1'b1;
    alloc(2, 32'h00A00093, 7'd5, 1'b1, 1'b1);
    check("t1_lat", 32'(iss.issue_valid), 0);
    cyc();
    check("t1_valid", 32'(iss.issue_valid), 1);
    check("t1_idx", 32'(iss.issue_idx), 2);
    check("t1_rd", 32'(iss.issue_rd), 5);
    check("t1_instr", iss.issue_instr, 32'h00A00093);
    check("t1_clear", 32'(clear), 1);
    check("t1_clridx", 32'(clear_idx), 2);
    cyc();
    check("t1_idle", 32'(iss.issue_valid), 0);
    check("t1_noclr", 32'(clear), 0);

    // oldest first, then back-to-back
    alloc(0, 32'hA0, 7'd10, 1'b0, 1'b0);
    alloc(3, 32'hA3, 7'd13, 1'b0, 1'b0);
    ent_rs1_ready[0] = 1'b1; ent_rs2_ready[0] = 1'b1;
    ent_rs1_ready[3] = 1'b1; ent_rs2_ready[3] = 1'b1;
    cyc();
    check("t2_idx0", 32'(iss.issue_idx), 0);
    check("t2_instr0", iss.issue_instr, 32'hA0);
    check("t2_clr0", 32'(clear), 1);
    cyc();
    check("t2_b2b_valid", 32'(iss.issue_valid), 1);
    check("t2_idx3", 32'(iss.issue_idx), 3);
    check("t2_rd3", 32'(iss.issue_rd), 13);
    check("t2_clridx3", 32'(clear_idx), 3);
    cyc();
    check("t2_idle", 32'(iss.issue_valid), 0);

    // stall for 5 cycles
    iss.issue_ready = 1'b0;
    alloc(1, 32'h11, 7'd21, 1'b1, 1'b1);
    cyc();
    for (int k = 0; k < 5; k++) begin
      check("t3_valid", 32'(iss.issue_valid), 1);
      check("t3_idx", 32'(iss.issue_idx), 1);
      check("t3_instr", iss.issue_instr, 32'h11);
      check("t3_clear", 32'(clear), 0);
      cyc();
    end
    iss.issue_ready = 1'b1;
    #1;
    check("t3_pulse", 32'(clear), 1);
    check("t3_pidx", 32'(clear_idx), 1);
    cyc();
    check("t3_after", 32'(clear), 0);
    check("t3_idle", 32'(iss.issue_valid), 0);

    // flush beats transfer
    iss.issue_ready = 1'b0;
    alloc(3, 32'h33, 7'd33, 1'b1, 1'b1);
    cyc();
    check("t4_held", 32'(iss.issue_idx), 3);
    flush = 1'b1;
    iss.issue_ready = 1'b1;
    #1;
    check("t4_noclr", 32'(clear), 0);
    cyc();
    flush = 1'b0;
    ent_valid[3] = 1'b0;
    #1;
    check("t4_valid", 32'(iss.issue_valid), 0);
    check("t4_noclr2", 32'(clear), 0);

    // equal saturated ages pick idx0 (wrap would pick idx1)
    iss.issue_ready = 1'b0;
    alloc(0, 32'hB0, 7'd40, 1'b0, 1'b0);
    alloc(1, 32'hB1, 7'd41, 1'b0, 1'b0);
    repeat (7) pulse(2);
    ent_rs1_ready[1:0] = 2'b11;
    ent_rs2_ready[1:0] = 2'b11;
    cyc();
    check("t5_idx0", 32'(iss.issue_idx), 0);
    check("t5_instr", iss.issue_instr, 32'hB0);
    iss.issue_ready = 1'b1;
    cyc();
    check("t5_idx1", 32'(iss.issue_idx), 1);
    cyc();
    check("t5_idle", 32'(iss.issue_valid), 0);

    // older higher index beats younger lower index; external kill
    iss.issue_ready = 1'b0;
    alloc(3, 32'hC3, 7'd53, 1'b0, 1'b0);
    alloc(1, 32'hC1, 7'd51, 1'b0, 1'b0);
    ent_rs1_ready[3] = 1'b1; ent_rs2_ready[3] = 1'b1;
    ent_rs1_ready[1] = 1'b1; ent_rs2_ready[1] = 1'b1;
    cyc();
    check("t7_idx3", 32'(iss.issue_idx), 3);
    ent_valid[3] = 1'b0;
    iss.issue_ready = 1'b1;
    #1;
    check("t7_killclr", 32'(clear), 0);
    cyc();
    check("t7_killed", 32'(iss.issue_valid), 0);
    cyc();
    check("t7_idx1", 32'(iss.issue_idx), 1);
    check("t7_clr1", 32'(clear), 1);
    cyc();
    check("t7_idle", 32'(iss.issue_valid), 0);

    // reset mid-HOLD clears slot and ages
    iss.issue_ready = 1'b0;
    alloc(1, 32'hD1, 7'd61, 1'b0, 1'b0);
    repeat (8) pulse(3);
    alloc(0, 32'hD0, 7'd60, 1'b0, 1'b0);
    alloc(2, 32'hD2, 7'd62, 1'b1, 1'b1);
    cyc();
    check("t6_held", 32'(iss.issue_idx), 2);
    reset = 1'b1;
    iss.issue_ready = 1'b1;
    #1;
    check("t6_rstclr", 32'(clear), 0);
    cyc();
    check("t6_valid", 32'(iss.issue_valid), 0);
    check("t6_instr", iss.issue_instr, 0);
    check("t6_rd", 32'(iss.issue_rd), 0);
    check("t6_idx", 32'(iss.issue_idx), 0);
    ent_valid[2] = 1'b0;
    reset = 1'b0;
    iss.issue_ready = 1'b0;
    ent_rs1_ready[1:0] = 2'b11;
    ent_rs2_ready[1:0] = 2'b11;
    #1;
    cyc();
    check("t6_age_idx", 32'(iss.issue_idx), 0);
    check("t6_age_rd", 32'(iss.issue_rd), 60);
    iss.issue_ready = 1'b1;
    cyc();
    check("t6_next", 32'(iss.issue_idx), 1);
    cyc();
    check("t6_idle", 32'(iss.issue_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
